// File: rtl/sram_stream_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram_stream_fifo_ctrl
//
// Purpose:
//   Wraps a 1W1R SRAM macro (DEPTH x DATA_W, one-cycle read latency) into a
//   ready/valid streaming FIFO for spectrometer sample/bin buffering. The
//   block sequences the SRAM write and read ports, keeps the pointers and
//   occupancy, and hides the read latency behind a 2-entry register
//   prefetch buffer. This lets it sustain one word per cycle with no
//   bubbles.
//
// Ports:
//   clock          single clock; also the SRAM R0/W0 clock
//   reset_n        asynchronous active-low reset
//   flush          synchronous clear of all contents (active-high)
//   in_valid/in_ready/in_data      upstream ready/valid port
//   out_valid/out_ready/out_data   downstream ready/valid port (head word)
//   count          words held: SRAM + in-flight read + prefetch buffer
//   sram_W0_*      SRAM write port (en/addr/data)
//   sram_R0_*      SRAM read port (en/addr); R0_data is valid the cycle
//                  after the enabling edge and is held afterwards
// ---------------------------------------------------------------------------
module sram_stream_fifo_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W+1:0] count,
    output logic              sram_W0_en,
    output logic [ADDR_W-1:0] sram_W0_addr,
    output logic [DATA_W-1:0] sram_W0_data,
    output logic              sram_R0_en,
    output logic [ADDR_W-1:0] sram_R0_addr,
    input  logic [DATA_W-1:0] sram_R0_data
);

    localparam logic [ADDR_W:0] SRAM_FULL = (ADDR_W+1)'(DEPTH);

    // Registered state
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   sram_cnt;
    logic              inflight;
    logic [1:0]        buf_cnt;
    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;

    // Next-state values
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [ADDR_W:0]   sram_cnt_nxt;
    logic              inflight_nxt;
    logic [1:0]        buf_cnt_nxt;
    logic [DATA_W-1:0] slot0_nxt;
    logic [DATA_W-1:0] slot1_nxt;

    // Per-cycle events
    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] buf_claim;
    logic [2:0] buf_room;

    // in_ready depends only on registered SRAM occupancy. This keeps
    // out_ready off the upstream timing path. The prefetch buffer adds
    // two words of capacity on top of the SRAM.
    assign in_ready  = (sram_cnt != SRAM_FULL);
    assign out_valid = (buf_cnt != 2'd0);

    // Flush overrides every transfer in its cycle.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Issue a read only when a buffer slot will still be free when the
    // data returns. Slots already claimed are the buffered words plus an
    // outstanding read. A pop in this cycle frees one slot.
    assign buf_claim = {1'b0, buf_cnt} + {2'b00, inflight};
    assign buf_room  = 3'd2 + {2'b00, pop};
    assign issue     = (sram_cnt != '0) & ~flush & (buf_claim < buf_room);

    // Next-state logic: pointers, SRAM occupancy, the in-flight flag and the
    // head-at-slot0 prefetch buffer. A captured word goes to the first free
    // slot once any pop has shifted slot1 down.
    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        sram_cnt_nxt = sram_cnt;
        inflight_nxt = issue;
        buf_cnt_nxt  = buf_cnt;
        slot0_nxt    = slot0;
        slot1_nxt    = slot1;

        if (flush) begin
            wr_ptr_nxt   = '0;
            rd_ptr_nxt   = '0;
            sram_cnt_nxt = '0;
            inflight_nxt = 1'b0;
            buf_cnt_nxt  = 2'd0;
            slot0_nxt    = '0;
            slot1_nxt    = '0;
        end else begin
            if (push) begin
                wr_ptr_nxt = wr_ptr + ADDR_W'(1);
            end
            if (issue) begin
                rd_ptr_nxt = rd_ptr + ADDR_W'(1);
            end

            case ({push, issue})
                2'b10:   sram_cnt_nxt = sram_cnt + (ADDR_W+1)'(1);
                2'b01:   sram_cnt_nxt = sram_cnt - (ADDR_W+1)'(1);
                default: sram_cnt_nxt = sram_cnt;
            endcase

            // inflight marks the cycle in which sram_R0_data holds the word
            // that was issued at the previous edge.
            case ({inflight, pop})
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        slot0_nxt = sram_R0_data;
                    end else begin
                        slot0_nxt = slot1;
                        slot1_nxt = sram_R0_data;
                    end
                end
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        slot0_nxt = sram_R0_data;
                    end else begin
                        slot1_nxt = sram_R0_data;
                    end
                    buf_cnt_nxt = buf_cnt + 2'd1;
                end
                2'b01: begin
                    slot0_nxt   = slot1;
                    buf_cnt_nxt = buf_cnt - 2'd1;
                end
                default: begin
                    buf_cnt_nxt = buf_cnt;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            sram_cnt <= sram_cnt_nxt;
            inflight <= inflight_nxt;
            buf_cnt  <= buf_cnt_nxt;
            slot0    <= slot0_nxt;
            slot1    <= slot1_nxt;
        end
    end

    // Output logic: SRAM port drive, head word and total occupancy.
    // rd_ptr never equals wr_ptr while the SRAM holds words and is not
    // full, and pushes stop at full. Same-cycle read and write therefore
    // never hit the same address.
    always_comb begin
        sram_W0_en   = push;
        sram_W0_addr = wr_ptr;
        sram_W0_data = in_data;
        sram_R0_en   = issue;
        sram_R0_addr = rd_ptr;
        out_data     = slot0;
        count        = (ADDR_W+2)'(sram_cnt) + (ADDR_W+2)'(inflight)
                     + (ADDR_W+2)'(buf_cnt);
    end

endmodule

// File: tb/tb_sram_stream_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_stream_fifo_ctrl
//
// Purpose:
//   Self-checking bench for sram_stream_fifo_ctrl. It contains a behavioural
//   256x32 SRAM with one-cycle read latency and a queue scoreboard. Accepted
//   pushes are queued, and a monitor pops and compares on each output
//   handshake. Directed sequences check reset values, latency, streaming,
//   full/drain, random traffic, flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_sram_stream_fifo_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W+1:0] count;
    logic              sram_W0_en;
    logic [ADDR_W-1:0] sram_W0_addr;
    logic [DATA_W-1:0] sram_W0_data;
    logic              sram_R0_en;
    logic [ADDR_W-1:0] sram_R0_addr;
    logic [DATA_W-1:0] sram_R0_data = '0;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] exp_q [$];

    int checks   = 0;
    int failures = 0;

    sram_stream_fifo_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .sram_W0_en   (sram_W0_en),
        .sram_W0_addr (sram_W0_addr),
        .sram_W0_data (sram_W0_data),
        .sram_R0_en   (sram_R0_en),
        .sram_R0_addr (sram_R0_addr),
        .sram_R0_data (sram_R0_data)
    );

    always #5 clock = ~clock;

    // Behavioural SRAM: write at the edge, read data registered at the edge
    // and held until the next read.
    always @(posedge clock) begin
        if (sram_W0_en) mem[sram_W0_addr] <= sram_W0_data;
        if (sram_R0_en) sram_R0_data <= mem[sram_R0_addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle. Flush and reset discard
    // everything expected so far, and any transfer in that cycle is void.
    always @(negedge clock) begin
        if (!reset_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output actual=0x%0h required=none", out_data);
                end else begin
                    check_output("out_data", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            checks++;
            if (count > 10'd258) begin
                failures++;
                $display("[TB] FAIL count_bound actual=%0d required<=258", count);
            end
            checks++;
            if (sram_W0_en && sram_R0_en && (sram_W0_addr == sram_R0_addr)) begin
                failures++;
                $display("[TB] FAIL addr_collision actual=0x%0h required=different", sram_W0_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic drain(input int budget);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < budget && count != 0; i++) tick();
        settle();
        check_output("drain_count", 32'(count), 32'd0);
        check_output("drain_queue", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    // Fills with out_ready low; returns the number of words accepted.
    task automatic fill(input logic [31:0] base, output int accepted);
        accepted = 0;
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'b1, base + 32'(accepted), 1'b0);
            settle();
            if (!in_ready) break;
            accepted++;
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_out;
        int last_out;
        int nout;
        int wraps;
        int accepted;
        logic seen;

        reset_n = 1'b0;
        flush   = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0);
        #12;
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_data", out_data, 32'd0);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_w0_en", 32'(sram_W0_en), 32'd0);
        check_output("rst_r0_en", 32'(sram_R0_en), 32'd0);
        check_output("rst_w0_addr", 32'(sram_W0_addr), 32'd0);
        check_output("rst_r0_addr", 32'(sram_R0_addr), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single word latency: R0_en pulses once; out_valid two cycles after the push edge
        apply_stimulus(1'b1, 32'hA5A5_0001, 1'b1);
        settle();
        check_output("single_w0_en", 32'(sram_W0_en), 32'd1);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        settle();
        check_output("single_r0_en_c1", 32'(sram_R0_en), 32'd1);
        check_output("single_count_c1", 32'(count), 32'd1);
        check_output("single_valid_c1", 32'(out_valid), 32'd0);
        tick();
        settle();
        check_output("single_r0_en_c2", 32'(sram_R0_en), 32'd0);
        check_output("single_count_c2", 32'(count), 32'd1);
        check_output("single_valid_c2", 32'(out_valid), 32'd0);
        tick();
        settle();
        check_output("single_valid_c3", 32'(out_valid), 32'd1);
        check_output("single_data_c3", out_data, 32'hA5A5_0001);
        check_output("single_count_c3", 32'(count), 32'd1);
        tick();
        settle();
        check_output("single_count_c4", 32'(count), 32'd0);
        check_output("single_valid_c4", 32'(out_valid), 32'd0);
        tick();

        // 600-word stream at full rate
        first_out = -1;
        last_out  = -1;
        nout      = 0;
        wraps     = 0;
        for (int cyc = 0; cyc < 620; cyc++) begin
            if (cyc < 600) apply_stimulus(1'b1, 32'(cyc), 1'b1);
            else           apply_stimulus(1'b0, 32'h0, 1'b1);
            settle();
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                nout++;
            end
            if (sram_W0_en && sram_W0_addr == 8'd255) wraps++;
            tick();
        end
        check_output("stream_first_cycle", 32'(first_out), 32'd3);
        check_output("stream_outputs", 32'(nout), 32'd600);
        check_output("stream_no_gaps", 32'(last_out - first_out), 32'd599);
        check_output("stream_wraps_ge2", 32'(wraps >= 2), 32'd1);
        drain(10);

        // Fill to full, offer an extra push, then drain 0..257
        fill(32'd0, accepted);
        check_output("full_accepted", 32'(accepted), 32'd258);
        check_output("full_count", 32'(count), 32'd258);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
            settle();
            check_output("full_w0_blocked", 32'(sram_W0_en), 32'd0);
            tick();
            settle();
            check_output("full_count_hold", 32'(count), 32'd258);
        end
        check_output("full_head", out_data, 32'd0);
        tick();
        drain(300);

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            tick();
        end
        drain(400);

        // Flush while (nearly) full, with a read in flight and a push offered
        fill(32'd1000, accepted);
        check_output("flush_fill", 32'(accepted), 32'd258);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        settle();
        check_output("flush_pre_issue", 32'(sram_R0_en), 32'd1);
        tick();
        flush = 1'b1;
        apply_stimulus(1'b1, 32'h5555_5555, 1'b1);
        settle();
        check_output("flush_pre_count", 32'(count), 32'd257);
        check_output("flush_w0_en", 32'(sram_W0_en), 32'd0);
        check_output("flush_r0_en", 32'(sram_R0_en), 32'd0);
        tick();
        flush = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0);
        settle();
        check_output("flush_count", 32'(count), 32'd0);
        check_output("flush_out_valid", 32'(out_valid), 32'd0);
        check_output("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        apply_stimulus(1'b1, 32'h0000_1234, 1'b1);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            settle();
            if (out_valid) begin
                seen = 1'b1;
                check_output("flush_first_out", out_data, 32'h0000_1234);
            end
            tick();
        end
        check_output("flush_out_seen", 32'(seen), 32'd1);
        drain(10);

        // Asynchronous reset mid-stream, then a fresh stream
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 32'(2000 + i), 1'b1);
            tick();
        end
        #3;
        reset_n = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0);
        #1;
        check_output("arst_out_valid", 32'(out_valid), 32'd0);
        check_output("arst_out_data", out_data, 32'd0);
        check_output("arst_count", 32'(count), 32'd0);
        check_output("arst_in_ready", 32'(in_ready), 32'd1);
        check_output("arst_r0_en", 32'(sram_R0_en), 32'd0);
        check_output("arst_w0_addr", 32'(sram_W0_addr), 32'd0);
        check_output("arst_r0_addr", 32'(sram_R0_addr), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) begin
            apply_stimulus(1'b1, 32'(3000 + i), 1'($urandom_range(0, 1)));
            tick();
        end
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
